// File: rtl/spec_accumulator.sv
// Spectrum accumulator: sums acc_num consecutive N_PTS-point power spectra bin-by-bin in an
// internal RAM, then streams the accumulated spectrum out once in bin order.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-low
//   acc_start  one-cycle pulse that arms a run (honoured only while idle)
//   acc_num    frames to sum, sampled with acc_start; 0 is treated as 1
//   in_data    per-bin power value
//   in_valid   in_data/in_index valid
//   in_index   bin index of in_data
//   out_data   accumulated bin value (holds when out_valid is low)
//   out_index  bin index of out_data (holds when out_valid is low)
//   out_valid  out_data/out_index valid
//   acc_done   one-cycle pulse with the final readout word
//   busy       high while armed, accumulating or reading out
//   frame_cnt  frames completed in the current run
//   drop_err   sticky: a sample arrived during readout and was dropped
//   sat_flag   sticky: some bin saturated at 2^ACC_W-1
module spec_accumulator #(
    parameter int unsigned N_PTS = 1024,
    parameter int unsigned IDX_W = 10,
    parameter int unsigned IN_W  = 32,
    parameter int unsigned ACC_W = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             acc_start,
    input  logic [15:0]      acc_num,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_index,
    output logic [ACC_W-1:0] out_data,
    output logic [IDX_W-1:0] out_index,
    output logic             out_valid,
    output logic             acc_done,
    output logic             busy,
    output logic [15:0]      frame_cnt,
    output logic             drop_err,
    output logic             sat_flag
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_PTS - 1);
    localparam logic [IDX_W:0]   RdEnd   = (IDX_W + 1)'(N_PTS);

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StAccum,
        StReadout
    } state_e;

    state_e state_q, state_d;

    logic [15:0]      acc_num_q, acc_num_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             drop_err_q, drop_err_d;
    logic             sat_q, sat_d;

    // Stage-1 registers: sample captured while its RAM read is in flight.
    logic             s1_valid_q, s1_valid_d;
    logic [IDX_W-1:0] s1_index_q, s1_index_d;
    logic [IN_W-1:0]  s1_data_q, s1_data_d;
    logic             s1_fwd_q, s1_fwd_d;
    logic [ACC_W-1:0] fwd_data_q, fwd_data_d;

    // Readout address counter; one extra count covers the trailing output cycle.
    logic [IDX_W:0]   rd_cnt_q, rd_cnt_d;

    logic             ov_q, ov_d;
    logic [IDX_W-1:0] oidx_q, oidx_d;
    logic [ACC_W-1:0] hold_q, hold_d;

    // RAM
    logic [ACC_W-1:0] mem [0:N_PTS-1];
    logic [ACC_W-1:0] ram_q;
    logic             ram_re;
    logic [IDX_W-1:0] ram_raddr;
    logic             ram_we;
    logic [IDX_W-1:0] ram_waddr;
    logic [ACC_W-1:0] ram_wdata;

    // Stage-2 arithmetic
    logic [ACC_W-1:0] base;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] wr_val;
    logic             sat_hit;
    logic             last_frame_done;
    logic             accept;
    logic             rd_issue;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        if (ram_re) begin
            ram_q <= mem[ram_raddr];
        end
    end

    // Stage 2: add the stored partial sum (or the word still being written by the
    // previous sample) to the new value, clamping at all-ones.
    always_comb begin
        base    = s1_fwd_q ? fwd_data_q : ram_q;
        sum_ext = {1'b0, base} + (ACC_W + 1)'(s1_data_q);
        wr_val  = sum_ext[ACC_W-1:0];
        sat_hit = 1'b0;
        if (frame_cnt_q == 16'd0) begin
            wr_val = ACC_W'(s1_data_q);
        end else if (sum_ext[ACC_W]) begin
            wr_val  = '1;
            sat_hit = 1'b1;
        end
    end

    assign last_frame_done = s1_valid_q && (s1_index_q == LastIdx) &&
                             ((frame_cnt_q + 16'd1) == acc_num_q);

    // Once the final sample of the run is in stage 2 nothing more is taken in, so no
    // write can land while the readout is scanning the RAM.
    always_comb begin
        accept = 1'b0;
        if (in_valid) begin
            if (state_q == StArm) begin
                accept = (in_index == '0);
            end else if (state_q == StAccum) begin
                accept = !last_frame_done;
            end
        end
    end

    assign rd_issue  = (state_q == StReadout) && (rd_cnt_q != RdEnd);

    assign ram_re    = accept || rd_issue;
    assign ram_raddr = accept ? in_index : rd_cnt_q[IDX_W-1:0];
    assign ram_we    = s1_valid_q;
    assign ram_waddr = s1_index_q;
    assign ram_wdata = wr_val;

    always_comb begin
        state_d     = state_q;
        acc_num_d   = acc_num_q;
        frame_cnt_d = frame_cnt_q;
        drop_err_d  = drop_err_q;
        sat_d       = sat_q;
        rd_cnt_d    = rd_cnt_q;
        oidx_d      = oidx_q;
        ov_d        = 1'b0;
        hold_d      = ov_q ? ram_q : hold_q;

        s1_valid_d  = accept;
        s1_index_d  = accept ? in_index : s1_index_q;
        s1_data_d   = accept ? in_data : s1_data_q;
        // The RAM read returns the pre-write word when a write hits the same address
        // in the same cycle, so carry the written value alongside.
        s1_fwd_d    = accept && ram_we && (ram_waddr == in_index);
        fwd_data_d  = ram_wdata;

        unique case (state_q)
            StIdle: begin
                if (acc_start) begin
                    state_d     = StArm;
                    acc_num_d   = (acc_num == 16'd0) ? 16'd1 : acc_num;
                    frame_cnt_d = 16'd0;
                    drop_err_d  = 1'b0;
                    sat_d       = 1'b0;
                    rd_cnt_d    = '0;
                end
            end
            StArm: begin
                if (accept) begin
                    state_d = StAccum;
                end
            end
            StAccum: begin
                if (last_frame_done) begin
                    state_d  = StReadout;
                    rd_cnt_d = '0;
                end
            end
            StReadout: begin
                if (in_valid) begin
                    drop_err_d = 1'b1;
                end
                if (rd_issue) begin
                    ov_d     = 1'b1;
                    oidx_d   = rd_cnt_q[IDX_W-1:0];
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (s1_valid_q) begin
            if (sat_hit) begin
                sat_d = 1'b1;
            end
            if (s1_index_q == LastIdx) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            acc_num_q   <= 16'd1;
            frame_cnt_q <= 16'd0;
            drop_err_q  <= 1'b0;
            sat_q       <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_index_q  <= '0;
            s1_data_q   <= '0;
            s1_fwd_q    <= 1'b0;
            fwd_data_q  <= '0;
            rd_cnt_q    <= '0;
            ov_q        <= 1'b0;
            oidx_q      <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            acc_num_q   <= acc_num_d;
            frame_cnt_q <= frame_cnt_d;
            drop_err_q  <= drop_err_d;
            sat_q       <= sat_d;
            s1_valid_q  <= s1_valid_d;
            s1_index_q  <= s1_index_d;
            s1_data_q   <= s1_data_d;
            s1_fwd_q    <= s1_fwd_d;
            fwd_data_q  <= fwd_data_d;
            rd_cnt_q    <= rd_cnt_d;
            ov_q        <= ov_d;
            oidx_q      <= oidx_d;
            hold_q      <= hold_d;
        end
    end

    // The RAM word is live only on valid cycles; otherwise show the last word output.
    assign out_data  = ov_q ? ram_q : hold_q;
    assign out_index = oidx_q;
    assign out_valid = ov_q;
    assign acc_done  = ov_q && (oidx_q == LastIdx);
    assign busy      = (state_q != StIdle);
    assign frame_cnt = frame_cnt_q;
    assign drop_err  = drop_err_q;
    assign sat_flag  = sat_q;

endmodule

// File: doc/spec_accumulator.md
Name: spec_accumulator

Overview:
- Downstream of the FFT power-spectrum stage.
- Consumes the per-bin 32-bit power stream (power value, valid, bin index) and sums acc_num consecutive 1024-point spectra bin-by-bin in an internal RAM.
- After the last frame, streams the accumulated spectrum out once in index order, ending with a done pulse. This output feeds range-bin storage and peak detection.

Parameters:
- N_PTS, 1024, points per spectrum frame; RAM depth.
- IDX_W, 10, bin index width (log2 N_PTS).
- IN_W, 32, input power width.
- ACC_W, 48, accumulator and output width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- acc_start  in  1  one-cycle pulse; arms an accumulation run.
- acc_num  in  16  frames to sum; sampled on acc_start; 0 treated as 1.
- in_data  in  IN_W  power value for one bin.
- in_valid  in  1  in_data/in_index valid this cycle.
- in_index  in  IDX_W  bin index of in_data.
- out_data  out  ACC_W  accumulated bin value.
- out_index  out  IDX_W  bin index of out_data.
- out_valid  out  1  out_data/out_index valid.
- acc_done  out  1  one-cycle pulse with the final readout word.
- busy  out  1  high in ARM, ACCUM and READOUT.
- frame_cnt  out  16  frames completed in the current run.
- drop_err  out  1  sticky; in_valid seen during READOUT.
- sat_flag  out  1  sticky; any bin saturated.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE.
  - out_data=0, out_index=0, out_valid=0, acc_done=0, busy=0, frame_cnt=0, drop_err=0, sat_flag=0.
  - RAM contents are don't-care.
  - Reset mid-run aborts the run immediately; no done pulse.
- States: IDLE, ARM, ACCUM, READOUT.
- IDLE:
  - in_valid is ignored.
  - acc_start -> ARM. On entry: latch acc_num (0 becomes 1), clear frame_cnt, drop_err and sat_flag.
- ARM:
  - Waits for in_valid with in_index==0; earlier samples are discarded, which aligns the run to a frame boundary.
  - That sample is processed as frame 0, and the state moves to ACCUM in the same cycle.
- ACCUM, per-sample pipeline:
  - Cycle t: in_valid, RAM read at in_index; register in_data and in_index.
  - Cycle t+1: sum = (frame_cnt==0) ? zero-extended in_data : ram_q + in_data. Write RAM[index_d1] with sum.
  - Forwarding: if the read address at t equals the write address at t (write from the previous sample), the forwarded write value is used instead of ram_q.
  - Saturation: if the true sum exceeds 2^ACC_W-1, write all-ones and set sat_flag.
  - in_valid with in_index==N_PTS-1 ends a frame; frame_cnt increments at t+1.
  - When the incremented frame_cnt equals the latched acc_num, go to READOUT on the cycle after the final write.
  - acc_start is ignored in ARM, ACCUM and READOUT.
  - Gaps in in_valid are allowed. Indices are assumed sequential; no sequence checking is done.
- READOUT:
  - Read address counter runs 0..N_PTS-1, one per cycle, with no stalls.
  - out_valid is high one cycle after each address (RAM latency 1). out_index = that address, out_data = RAM word.
  - acc_done pulses with out_index==N_PTS-1. The next cycle goes to IDLE with out_valid=0.
  - Total duration: N_PTS+1 cycles.
  - in_valid during READOUT is dropped and sets drop_err; the sample is not written.
- out_data and out_index hold their last values when out_valid=0.

Test Plan:
- acc_num=1, frame with in_data=index*2 -> out_valid for 1024 consecutive cycles, out_data[k]=2k. acc_done with out_index=1023; frame_cnt=1.
- acc_num=4, every frame in_data=100 with random in_valid gaps -> all out_data=400, sat_flag=0. READOUT starts exactly 2 cycles after the last in_valid.
- acc_start issued mid-frame (in_index=500 next) -> samples 500..1023 discarded. Accumulation begins at the next index 0. acc_num=2 gives out_data=2*in_data.
- ACC_W=33, acc_num=3, in_data=0xFFFFFFFF -> out_data=0x1_FFFFFFFF (saturated), sat_flag=1.
- acc_num=0 -> behaves as 1: single frame, frame_cnt=1, done after readout.
- in_valid pulses during READOUT -> drop_err=1, readout values unchanged. Then rst=0 mid-READOUT -> all outputs 0 next cycle, no acc_done, state IDLE.
